vertex_sequencer: RTL
=====================

VERTEX_SEQUENCER -- requirements
Module: vertex_sequencer

Interface
REQ-001 SHALL have parameter NUM_VERTS, default 18, meaning the number of model vertices processed per frame (2..255).
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 4, meaning the maximum number of transforms issued but not yet returned (1..15).
REQ-003 SHALL have port clk, input, 1, the clock.
REQ-004 SHALL have port rst, input, 1, the reset: synchronous, active-high.
REQ-005 SHALL have port frame_start, input, 1, a one-cycle pulse that starts a frame pass.
REQ-006 SHALL have port ang_x_in/ang_y_in/ang_z_in, input, 16 each, signed rotation angles.
REQ-007 SHALL have port ang_x/ang_y/ang_z, output, 16 each, latched angles supplied to the transform unit.
REQ-008 SHALL have port vtx_idx, output, 8, the model vertex read index.
REQ-009 SHALL have port vtx_x/vtx_y/vtx_z, input, 16 each, signed vertex data, combinationally valid for vtx_idx in the same cycle.
REQ-010 SHALL have port xf_valid, output, 1, and port xf_ready, input, 1, the transform request handshake.
REQ-011 SHALL have port xf_x/xf_y/xf_z, output, 16 each, the request payload.
REQ-012 SHALL have port res_valid, input, 1, and port res_x/res_y, input, 11 each, signed projected results; results return in issue order with no backpressure.
REQ-013 SHALL have port wr_en, output, 1; port wr_idx, output, 8; and ports wr_x/wr_y, output, 10 each, the 2D vertex buffer write port.
REQ-014 SHALL have port busy, output, 1; port done, output, 1 (pulse); and port err, output, 1 (sticky).

Function
REQ-015 SHALL implement states IDLE, ISSUE, DRAIN, DONE.
REQ-016 IDLE: frame_start moves the FSM to ISSUE, latches ang_*_in into ang_*, and clears the issue count, return count and outstanding count.
REQ-017 ISSUE: xf_valid=1 whenever outstanding < MAX_OUTSTANDING, else 0.
REQ-018 ISSUE: vtx_idx equals the issue count; xf_x/y/z equal vtx_x/y/z.
REQ-019 A transfer occurs on xf_valid&xf_ready; it increments the issue count and the outstanding count.
REQ-020 xf_valid SHALL NOT drop while xf_ready is low, except when the outstanding count is at its limit, which is checked before assertion.
REQ-021 After the transfer with issue count == NUM_VERTS-1, the FSM moves to DRAIN; xf_valid=0 in DRAIN, DONE and IDLE.
REQ-022 res_valid with outstanding > 0 decrements the outstanding count; a simultaneous transfer and res_valid leaves the outstanding count unchanged.
REQ-023 res_valid with outstanding == 0 SHALL be ignored (no write) and SHALL set err.
REQ-024 Write latency is 1 cycle: wr_en=1 in the cycle after each accepted res_valid, with wr_idx equal to the return count and the return count then incremented.
REQ-025 wr_x = clamp(res_x, 0, 639); wr_y = clamp(res_y, 0, 479); negative values become 0.
REQ-026 When the return count reaches NUM_VERTS (after the last wr_en), the FSM enters DONE; done=1 for exactly that one cycle; the next cycle is IDLE.
REQ-027 busy=1 in ISSUE and DRAIN, and 0 otherwise.
REQ-028 frame_start while busy or in DONE SHALL be ignored and SHALL set err; the pass in progress is unaffected.
REQ-029 ang_* SHALL remain constant from the latch until the next accepted frame_start.
REQ-030 Counters SHALL NOT wrap within a pass; the index never exceeds NUM_VERTS-1.

Reset
REQ-031 rst SHALL return the FSM to IDLE from any state, including mid-pass; outstanding results arriving after rst are treated as in REQ-023.
REQ-032 Reset values: xf_valid=0, wr_en=0, busy=0, done=0, err=0; vtx_idx, wr_idx, wr_x, wr_y, xf_* and ang_* all 0; all counters 0.

Verification
REQ-033 Scenario 1 (nominal): xf_ready=1, results returned 3 cycles after issue, NUM_VERTS=18 -> 18 writes with wr_idx 0..17 in order and one done pulse; busy drops when done rises.
REQ-034 Scenario 2 (outstanding limit): xf_ready=1, results held off for 10 cycles -> exactly 4 transfers, then xf_valid=0 until the first res_valid, then issue resumes.
REQ-035 Scenario 3 (backpressure): xf_ready toggling 1,0,0,1 -> payload stable while stalled; no vertex skipped or duplicated; sequence 0..17.
REQ-036 Scenario 4 (clamping): res_x=-5, res_y=700 -> wr_x=0, wr_y=479; res_x=639, res_y=0 -> passed unchanged.
REQ-037 Scenario 5 (errors): frame_start at issue count 5 -> err=1 with the pass completing normally; spurious res_valid in IDLE -> no wr_en, err=1.
REQ-038 Scenario 6 (reset mid-pass): rst at issue count 9 -> next cycle IDLE with all outputs at reset values; a following frame_start runs a full clean 18-vertex pass.

Source files
------------

// File: rtl/vertex_sequencer.sv
// Streams model vertices to the transform unit and writes clamped 2D results to the vertex buffer.
// Issue is combinational from vtx data, writes trail accepted results by 1 cycle; issue stalls on xf_ready or the outstanding limit.
module vertex_sequencer #(
    parameter int NUM_VERTS       = 18,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_start,
    input  logic signed [15:0] ang_x_in,
    input  logic signed [15:0] ang_y_in,
    input  logic signed [15:0] ang_z_in,
    output logic signed [15:0] ang_x,
    output logic signed [15:0] ang_y,
    output logic signed [15:0] ang_z,
    output logic        [7:0]  vtx_idx,
    input  logic signed [15:0] vtx_x,
    input  logic signed [15:0] vtx_y,
    input  logic signed [15:0] vtx_z,
    output logic               xf_valid,
    input  logic               xf_ready,
    output logic signed [15:0] xf_x,
    output logic signed [15:0] xf_y,
    output logic signed [15:0] xf_z,
    input  logic               res_valid,
    input  logic signed [10:0] res_x,
    input  logic signed [10:0] res_y,
    output logic               wr_en,
    output logic        [7:0]  wr_idx,
    output logic        [9:0]  wr_x,
    output logic        [9:0]  wr_y,
    output logic               busy,
    output logic               done,
    output logic               err
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t     state;
    logic [7:0] issue_cnt;
    logic [7:0] ret_cnt;
    logic [3:0] outstanding;
    logic       xfer;
    logic       res_acc;
    logic       last_issue;

    function automatic logic [9:0] clamp(input logic signed [10:0] v, input logic [9:0] hi);
        if (v < 11'sd0) return 10'd0;
        if (v > $signed({1'b0, hi})) return hi;
        return v[9:0];
    endfunction

    // The limit is checked before asserting, so valid never drops under backpressure.
    assign xf_valid   = (state == ISSUE) && (outstanding < 4'(MAX_OUTSTANDING));
    assign vtx_idx    = issue_cnt;
    assign xf_x       = xf_valid ? vtx_x : 16'sd0;
    assign xf_y       = xf_valid ? vtx_y : 16'sd0;
    assign xf_z       = xf_valid ? vtx_z : 16'sd0;
    assign xfer       = xf_valid && xf_ready;
    assign res_acc    = res_valid && (outstanding != 4'd0);
    assign last_issue = (issue_cnt == 8'(NUM_VERTS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            issue_cnt   <= 8'd0;
            ret_cnt     <= 8'd0;
            outstanding <= 4'd0;
            ang_x       <= 16'sd0;
            ang_y       <= 16'sd0;
            ang_z       <= 16'sd0;
            wr_en       <= 1'b0;
            wr_idx      <= 8'd0;
            wr_x        <= 10'd0;
            wr_y        <= 10'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            wr_en       <= res_acc;
            done        <= 1'b0;
            outstanding <= outstanding + 4'(xfer) - 4'(res_acc);
            if (res_acc) begin
                wr_idx  <= ret_cnt;
                wr_x    <= clamp(res_x, 10'd639);
                wr_y    <= clamp(res_y, 10'd479);
                ret_cnt <= ret_cnt + 8'd1;
            end
            // Results with nothing in flight are stale or spurious.
            if (res_valid && (outstanding == 4'd0))
                err <= 1'b1;
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        state       <= ISSUE;
                        busy        <= 1'b1;
                        ang_x       <= ang_x_in;
                        ang_y       <= ang_y_in;
                        ang_z       <= ang_z_in;
                        issue_cnt   <= 8'd0;
                        ret_cnt     <= 8'd0;
                        outstanding <= 4'd0;
                    end
                end
                ISSUE: begin
                    if (frame_start)
                        err <= 1'b1;
                    if (xfer) begin
                        if (last_issue)
                            state <= DRAIN;
                        else
                            issue_cnt <= issue_cnt + 8'd1;
                    end
                end
                DRAIN: begin
                    if (frame_start)
                        err <= 1'b1;
                    if (wr_en && (ret_cnt == 8'(NUM_VERTS))) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    if (frame_start)
                        err <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
